// File: rtl/mem_stage.sv
// Memory-access pipeline stage: captures the EX_to_MEM bus, extracts and
// extends load data from the synchronous data SRAM, forwards to WB and
// reports MEM-stage bypass/hazard information back to ID.
// Optional feature macro: MEM_LOAD_FWD_EN (load data forwardable to ID in MEM).
module mem_stage #(
  parameter int unsigned EX_MEM_BUS_W = 75,
  parameter int unsigned MEM_WB_BUS_W = 70,
  parameter int unsigned FWD_W        = 38
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    WB_allow,
  output logic                    MEM_allow,
  input  logic                    EX_to_MEM_valid,
  input  logic [EX_MEM_BUS_W-1:0] EX_to_MEM_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic                    MEM_to_WB_valid,
  output logic [MEM_WB_BUS_W-1:0] MEM_to_WB_bus,
  output logic [FWD_W-1:0]        MEM_to_ID_forward,
  output logic                    MEM_to_ID_load_up
);

  logic                    mem_valid;
  logic                    first_cycle;
  logic [31:0]             rdata_hold;
  logic [EX_MEM_BUS_W-1:0] bus_q;

  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] result;
  logic [31:0] pc;
  logic        is_ld_b;
  logic        is_ld_h;
  logic        is_ld_bu;
  logic        is_ld_hu;

  logic        mem_ready_go;
  logic [31:0] raw_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic [31:0] fwd_data;

  assign res_from_mem = bus_q[74];
  assign gr_we        = bus_q[73];
  assign dest         = bus_q[72:68];
  assign result       = bus_q[67:36];
  assign pc           = bus_q[35:4];
  assign is_ld_b      = bus_q[3];
  assign is_ld_h      = bus_q[2];
  assign is_ld_bu     = bus_q[1];
  assign is_ld_hu     = bus_q[0];

  // MEM never stalls on its own; only WB back-pressure holds it.
  assign mem_ready_go    = 1'b1;
  assign MEM_allow       = !mem_valid || (mem_ready_go && WB_allow);
  assign MEM_to_WB_valid = mem_valid && mem_ready_go;

  // Pipeline register: take a new instruction whenever MEM can accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid   <= 1'b0;
      first_cycle <= 1'b0;
      bus_q       <= '0;
    end else begin
      if (MEM_allow) begin
        mem_valid <= EX_to_MEM_valid;
      end
      if (EX_to_MEM_valid && MEM_allow) begin
        bus_q       <= EX_to_MEM_bus;
        first_cycle <= 1'b1;
      end else begin
        first_cycle <= 1'b0;
      end
    end
  end

  // SRAM data is only valid in the first MEM cycle; keep it for stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_hold <= '0;
    end else if (mem_valid && first_cycle) begin
      rdata_hold <= data_sram_rdata;
    end
  end

  // Load extraction; misaligned half/word accesses use the aligned view.
  always_comb begin
    raw_word = first_cycle ? data_sram_rdata : rdata_hold;
    unique case (result[1:0])
      2'b00:   ld_byte = raw_word[7:0];
      2'b01:   ld_byte = raw_word[15:8];
      2'b10:   ld_byte = raw_word[23:16];
      default: ld_byte = raw_word[31:24];
    endcase
    ld_half = result[1] ? raw_word[31:16] : raw_word[15:0];
    if (is_ld_b) begin
      load_data = {{24{ld_byte[7]}}, ld_byte};
    end else if (is_ld_bu) begin
      load_data = {24'b0, ld_byte};
    end else if (is_ld_h) begin
      load_data = {{16{ld_half[15]}}, ld_half};
    end else if (is_ld_hu) begin
      load_data = {16'b0, ld_half};
    end else begin
      load_data = raw_word;
    end
    final_result = res_from_mem ? load_data : result;
  end

  // For loads final_result already is the extended load data, so the data
  // field is the same in both builds; only the hazard flag differs.
  assign fwd_data = final_result;

  assign MEM_to_WB_bus     = {gr_we, dest, final_result, pc};
  assign MEM_to_ID_forward = {gr_we && mem_valid, dest & {5{mem_valid}}, fwd_data};

`ifdef MEM_LOAD_FWD_EN
  assign MEM_to_ID_load_up = 1'b0;
`else
  // ID must wait one more cycle for a load result.
  assign MEM_to_ID_load_up = mem_valid && res_from_mem;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        WB_allow;
  logic        MEM_allow;
  logic        EX_to_MEM_valid;
  logic [74:0] EX_to_MEM_bus;
  logic [31:0] data_sram_rdata;
  logic        MEM_to_WB_valid;
  logic [69:0] MEM_to_WB_bus;
  logic [37:0] MEM_to_ID_forward;
  logic        MEM_to_ID_load_up;

  int vectors;
  int miscompares;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .WB_allow          (WB_allow),
    .MEM_allow         (MEM_allow),
    .EX_to_MEM_valid   (EX_to_MEM_valid),
    .EX_to_MEM_bus     (EX_to_MEM_bus),
    .data_sram_rdata   (data_sram_rdata),
    .MEM_to_WB_valid   (MEM_to_WB_valid),
    .MEM_to_WB_bus     (MEM_to_WB_bus),
    .MEM_to_ID_forward (MEM_to_ID_forward),
    .MEM_to_ID_load_up (MEM_to_ID_load_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load kinds (flags order {ld_b, ld_h, ld_bu, ld_hu}).
  localparam logic [3:0] LdW  = 4'b0000;
  localparam logic [3:0] LdB  = 4'b1000;
  localparam logic [3:0] LdH  = 4'b0100;
  localparam logic [3:0] LdBu = 4'b0010;
  localparam logic [3:0] LdHu = 4'b0001;

  typedef struct {
    logic        res_from_mem;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [31:0] rdata;
    logic [31:0] expect_res;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [74:0] mk_bus(input logic rfm, input logic we, input logic [4:0] d,
                                         input logic [31:0] res, input logic [31:0] pc,
                                         input logic [3:0] flags);
    return {rfm, we, d, res, pc, flags};
  endfunction

  // Reference extraction from the load rules, using plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [3:0] flags, input logic [1:0] a,
                                           input logic [31:0] w);
    int unsigned bytev;
    int unsigned halfv;
    bytev = (w >> (8 * int'(a))) % 256;
    halfv = (a >= 2) ? (w >> 16) : (w % 65536);
    case (flags)
      LdB:     return (bytev >= 128) ? (32'hFFFF_FF00 + bytev) : bytev;
      LdBu:    return bytev;
      LdH:     return (halfv >= 32768) ? (32'hFFFF_0000 + halfv) : halfv;
      LdHu:    return halfv;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  logic exp_lu;

  // Reference model state: the instruction held in MEM, if any.
  logic        m_occ;
  logic        m_first;
  logic [74:0] m_bus;
  logic [31:0] m_word;

  task automatic model_check();
    logic [31:0] w;
    logic [31:0] fin;
    w   = m_first ? data_sram_rdata : m_word;
    fin = m_bus[74] ? ref_load(m_bus[3:0], m_bus[37:36], w) : m_bus[67:36];
    chk("rnd_valid", 70'(MEM_to_WB_valid), 70'(m_occ));
    chk("rnd_allow", 70'(MEM_allow), 70'(!m_occ || WB_allow));
    if (m_occ) begin
      chk("rnd_wb_bus", MEM_to_WB_bus, {m_bus[73], m_bus[72:68], fin, m_bus[35:4]});
      chk("rnd_fwd", 70'(MEM_to_ID_forward), 70'({m_bus[73], m_bus[72:68], fin}));
`ifdef MEM_LOAD_FWD_EN
      chk("rnd_load_up", 70'(MEM_to_ID_load_up), 70'(0));
`else
      chk("rnd_load_up", 70'(MEM_to_ID_load_up), 70'(m_bus[74]));
`endif
    end else begin
      chk("rnd_fwd_bubble", 70'(MEM_to_ID_forward[37:32]), 70'(0));
      chk("rnd_load_up_bubble", 70'(MEM_to_ID_load_up), 70'(0));
    end
  endtask

  // Advance the model across the coming clock edge.
  task automatic model_step();
    logic allow;
    allow = !m_occ || WB_allow;
    if (m_occ && m_first) m_word = data_sram_rdata;
    if (allow && EX_to_MEM_valid) begin
      m_occ   = 1'b1;
      m_first = 1'b1;
      m_bus   = EX_to_MEM_bus;
    end else begin
      if (allow) m_occ = 1'b0;
      m_first = 1'b0;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    vecs[0] = '{1'b0, 5'd5,  32'h1234_5678, LdW,  32'h0000_0000, 32'h1234_5678};
    vecs[1] = '{1'b1, 5'd7,  32'h0000_1003, LdB,  32'h80FF_7F01, 32'hFFFF_FF80};
    vecs[2] = '{1'b1, 5'd8,  32'h0000_1002, LdBu, 32'h80FF_7F01, 32'h0000_00FF};
    vecs[3] = '{1'b1, 5'd9,  32'h0000_1000, LdH,  32'h80FF_7F01, 32'h0000_7F01};
    vecs[4] = '{1'b1, 5'd10, 32'h0000_1002, LdHu, 32'h80FF_7F01, 32'h0000_80FF};
    vecs[5] = '{1'b1, 5'd11, 32'h0000_1001, LdW,  32'h80FF_7F01, 32'h80FF_7F01};
    vecs[6] = '{1'b1, 5'd12, 32'h0000_1003, LdH,  32'h80FF_7F01, 32'hFFFF_80FF};
    vecs[7] = '{1'b1, 5'd13, 32'h0000_1000, LdB,  32'h80FF_7F01, 32'h0000_0001};

    resetn          = 1'b0;
    WB_allow        = 1'b1;
    EX_to_MEM_valid = 1'b0;
    EX_to_MEM_bus   = '0;
    data_sram_rdata = '0;
    #7;
    chk("reset_valid", 70'(MEM_to_WB_valid), 70'(0));
    chk("reset_allow", 70'(MEM_allow), 70'(1));
    chk("reset_fwd", 70'(MEM_to_ID_forward), 70'(0));
    chk("reset_load_up", 70'(MEM_to_ID_load_up), 70'(0));
    @(negedge clk);
    resetn = 1'b1;

    // Directed single-instruction table.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      EX_to_MEM_valid = 1'b1;
      EX_to_MEM_bus   = mk_bus(vecs[i].res_from_mem, 1'b1, vecs[i].dest, vecs[i].result,
                               32'h0000_4000 + 32'(i * 4), vecs[i].flags);
      @(negedge clk);
      EX_to_MEM_valid = 1'b0;
      data_sram_rdata = vecs[i].rdata;
      #1;
      chk("tbl_valid", 70'(MEM_to_WB_valid), 70'(1));
      chk("tbl_wb_bus", MEM_to_WB_bus,
          {1'b1, vecs[i].dest, vecs[i].expect_res, 32'h0000_4000 + 32'(i * 4)});
      chk("tbl_fwd", 70'(MEM_to_ID_forward), 70'({1'b1, vecs[i].dest, vecs[i].expect_res}));
`ifdef MEM_LOAD_FWD_EN
      exp_lu = 1'b0;
`else
      exp_lu = vecs[i].res_from_mem;
`endif
      chk("tbl_load_up", 70'(MEM_to_ID_load_up), 70'(exp_lu));
    end
    @(negedge clk);
    #1;
    chk("tbl_drain", 70'(MEM_to_WB_valid), 70'(0));
    chk("tbl_bubble_fwd", 70'(MEM_to_ID_forward[37:32]), 70'(0));

    // Stall hold: read data must survive WB back-pressure.
    @(negedge clk);
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus   = mk_bus(1'b1, 1'b1, 5'd3, 32'h0000_2000, 32'h0000_5000, LdW);
    WB_allow        = 1'b0;
    @(negedge clk);
    EX_to_MEM_valid = 1'b0;
    data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("stall_first", 70'(MEM_to_WB_bus[63:32]), 70'(32'hDEAD_BEEF));
    chk("stall_allow0", 70'(MEM_allow), 70'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_sram_rdata = 32'h0;
      #1;
      chk("stall_hold", 70'(MEM_to_WB_bus[63:32]), 70'(32'hDEAD_BEEF));
      chk("stall_allow", 70'(MEM_allow), 70'(0));
      chk("stall_valid", 70'(MEM_to_WB_valid), 70'(1));
    end
    @(negedge clk);
    WB_allow = 1'b1;
    #1;
    chk("stall_release", 70'(MEM_to_WB_valid), 70'(1));
    chk("stall_release_data", 70'(MEM_to_WB_bus[63:32]), 70'(32'hDEAD_BEEF));
    @(negedge clk);
    #1;
    chk("stall_one_handoff", 70'(MEM_to_WB_valid), 70'(0));

    // Back-to-back loads, each using only its own first-cycle data.
    @(negedge clk);
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus   = mk_bus(1'b1, 1'b1, 5'd1, 32'h0000_3000, 32'h0000_6000, LdW);
    @(negedge clk);
    EX_to_MEM_bus   = mk_bus(1'b1, 1'b1, 5'd2, 32'h0000_3004, 32'h0000_6004, LdW);
    data_sram_rdata = 32'h1111_1111;
    #1;
    chk("b2b_first", MEM_to_WB_bus, {1'b1, 5'd1, 32'h1111_1111, 32'h0000_6000});
    @(negedge clk);
    EX_to_MEM_valid = 1'b0;
    data_sram_rdata = 32'h2222_2222;
    #1;
    chk("b2b_second_valid", 70'(MEM_to_WB_valid), 70'(1));
    chk("b2b_second", MEM_to_WB_bus, {1'b1, 5'd2, 32'h2222_2222, 32'h0000_6004});
    @(negedge clk);

    // Reset asserted while a load is held.
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus   = mk_bus(1'b1, 1'b1, 5'd4, 32'h0000_3008, 32'h0000_7000, LdW);
    WB_allow        = 1'b0;
    @(negedge clk);
    EX_to_MEM_valid = 1'b0;
    data_sram_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_stall_valid", 70'(MEM_to_WB_valid), 70'(0));
    chk("rst_stall_fwd", 70'(MEM_to_ID_forward), 70'(0));
    chk("rst_stall_load_up", 70'(MEM_to_ID_load_up), 70'(0));
    chk("rst_stall_allow", 70'(MEM_allow), 70'(1));
    @(negedge clk);
    resetn   = 1'b1;
    WB_allow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_stall_after", 70'(MEM_to_WB_valid), 70'(0));
      @(negedge clk);
    end

    // Randomized run against the reference model.
    m_occ   = 1'b0;
    m_first = 1'b0;
    m_bus   = '0;
    m_word  = '0;
    for (int c = 0; c < 600; c++) begin
      logic [3:0] fl;
      case ($urandom_range(0, 4))
        0:       fl = LdW;
        1:       fl = LdB;
        2:       fl = LdH;
        3:       fl = LdBu;
        default: fl = LdHu;
      endcase
      EX_to_MEM_valid = ($urandom_range(0, 2) != 0);
      EX_to_MEM_bus   = mk_bus(1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom, fl);
      WB_allow        = ($urandom_range(0, 9) < 7);
      data_sram_rdata = $urandom;
      #1;
      model_check();
      model_step();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits directly downstream of ex_stage and upstream of the write-back stage.
- Accepts the EX_to_MEM bus and the synchronous data-SRAM read data for the request that EX issued.
- Extracts and sign/zero-extends load data, then forwards the result to WB.
- Drives the MEM-stage bypass/hazard information back to ID.
- Holds captured read data stable across WB back-pressure stalls.

Parameters:
- EX_MEM_BUS_W, 75, width of EX_to_MEM_bus.
- MEM_WB_BUS_W, 70, width of MEM_to_WB_bus.
- FWD_W, 38, width of MEM_to_ID_forward.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- WB_allow  input  1  WB can accept an instruction this cycle
- MEM_allow  output  1  MEM can accept from EX this cycle
- EX_to_MEM_valid  input  1  EX presents a valid instruction
- EX_to_MEM_bus  input  75  {res_from_mem, gr_we, dest[4:0], result[31:0], pc[31:0], is_ld_b, is_ld_h, is_ld_bu, is_ld_hu}, MSB first
- data_sram_rdata  input  32  SRAM read word; valid only in the first MEM cycle of a load
- MEM_to_WB_valid  output  1  valid instruction to WB
- MEM_to_WB_bus  output  70  {gr_we, dest[4:0], final_result[31:0], pc[31:0]}, MSB first
- MEM_to_ID_forward  output  38  {gr_we&valid, dest masked by valid, final_result}
- MEM_to_ID_load_up  output  1  load in MEM whose data is not forwardable

Behaviour:
- Reset: async on resetn low; all registers clear while resetn is low.
  - Cleared registers: MEM_valid, first_cycle, rdata_hold, bus register.
  - Reset output values: MEM_to_WB_valid=0, MEM_allow=1, MEM_to_ID_forward=0, MEM_to_ID_load_up=0.
- Handshake:
  - MEM_ready_go=1.
  - MEM_allow = !MEM_valid || WB_allow.
  - MEM_to_WB_valid = MEM_valid.
  - At posedge, if MEM_allow: MEM_valid <= EX_to_MEM_valid.
  - If EX_to_MEM_valid && MEM_allow: the bus register captures EX_to_MEM_bus and first_cycle <= 1.
  - Otherwise first_cycle <= 0.
  - Latency: 1 cycle from EX handoff to MEM_to_WB_valid, with no stall.
- Read-data capture:
  - When MEM_valid && first_cycle: raw word = data_sram_rdata (live), and rdata_hold <= data_sram_rdata.
  - In later cycles of the same instruction: raw word = rdata_hold.
  - rdata_hold is untouched when no instruction is in MEM.
- Load extraction, with a = result[1:0]:
  - ld.b / ld.bu: byte raw[8a+7:8a], sign-extended / zero-extended.
  - ld.h / ld.hu: half raw[31:16] if a[1] else raw[15:0], sign-extended / zero-extended.
  - No ld flag set: full word (ld.w).
  - Misaligned half/word: the low address bits are ignored (word/half-aligned view).
- final_result = res_from_mem ? load_data : result.
- Simultaneous events: WB drains and EX delivers in the same cycle. MEM takes the new instruction with no bubble, and first_cycle re-arms.
- Back-to-back loads: each instruction uses only its own first-cycle rdata.
- A stall of any length must not alter final_result.
- Bubble: MEM_valid=0 masks gr_we and dest in the forward bus to 0; MEM_to_ID_load_up=0.
- Reset asserted mid-stall: the instruction is dropped and no MEM_to_WB_valid pulse occurs after release.

Optional Feature:
- Macro: MEM_LOAD_FWD_EN.
- Defined:
  - The forward bus carries the extended load data.
  - MEM_to_ID_load_up is tied 0.
- Undefined:
  - The forward bus carries final_result; for loads this is still valid in the first cycle, but ID must not use it.
  - MEM_to_ID_load_up = MEM_valid & res_from_mem, so ID stalls the dependent instruction one extra cycle.

Test Plan:
- ALU op, no stall: bus with result=0x1234_5678, gr_we=1, dest=5 -> next cycle MEM_to_WB_valid=1, final_result=0x1234_5678, forward={1,5,0x12345678}.
- Loads, rdata=0x80FF_7F01:
  - ld.b with addr low bits 2'b11 -> 0xFFFF_FF80.
  - ld.bu with addr low bits 2'b10 -> 0x0000_00FF.
  - ld.h with addr low bits 2'b00 -> 0x0000_7F01.
  - ld.hu with addr low bits 2'b10 -> 0x0000_80FF.
- Stall hold: ld.w, rdata=0xDEAD_BEEF in the first cycle, then rdata changes to 0 while WB_allow=0 for 3 cycles -> final_result stays 0xDEAD_BEEF, MEM_allow=0 throughout, one WB handoff on release.
- Back-to-back: two ld.w with rdata 0x11111111 then 0x22222222, WB_allow=1 -> WB sees 0x11111111 then 0x22222222 on consecutive cycles.
- Reset mid-stall: resetn low for 1 cycle while a load is held -> MEM_to_WB_valid=0 immediately and stays 0, forward=0.
- Load-up:
  - Without MEM_LOAD_FWD_EN: a valid load in MEM gives MEM_to_ID_load_up=1.
  - With MEM_LOAD_FWD_EN: load_up=0 and forward data=extended load data.
